// File: rtl/lu_pkg.sv
// Shared definitions for the pipelined logic unit.
//   lu_op_e            : 4-bit opcode encoding used on in_op
//   LU_OP_ILLEGAL_MIN  : first opcode value with no defined operation
//   lu_op_is_illegal() : true for opcodes at or above LU_OP_ILLEGAL_MIN
package lu_pkg;

  typedef enum logic [3:0] {
    LU_AND  = 4'd0,
    LU_OR   = 4'd1,
    LU_NOR  = 4'd2,
    LU_NOT  = 4'd3,
    LU_XOR  = 4'd4,
    LU_NAND = 4'd5,
    LU_XNOR = 4'd6,
    LU_NEG  = 4'd7,
    LU_SHL  = 4'd8,
    LU_SHR  = 4'd9,
    LU_SRA  = 4'd10,
    LU_ROL  = 4'd11,
    LU_ROR  = 4'd12
  } lu_op_e;

  localparam logic [3:0] LU_OP_ILLEGAL_MIN = 4'd13;

  function automatic logic lu_op_is_illegal(input logic [3:0] op);
    return op >= LU_OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/lu_core.sv
// Combinational datapath of the logic unit.
//   op   : opcode (lu_op_e encoding)
//   a, b : operands; shift/rotate amount is b[SH_W-1:0]
//   res  : result, forced to 0 for illegal opcodes
//   cout : carry out of NEG (~a + 1), 0 for all other ops
//   err  : illegal opcode
module lu_core
  import lu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             err
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]    sh;
  logic [WIDTH:0]     neg_sum;
  logic [2*WIDTH-1:0] rol_full;
  logic [2*WIDTH-1:0] ror_full;
  logic [WIDTH-1:0]   sra;

  assign sh = b[SH_W-1:0];

  // One extra bit captures the carry of ~a + 1; it is set only when a == 0.
  assign neg_sum = {1'b0, ~a} + {{WIDTH{1'b0}}, 1'b1};

  // Rotates as shifts of the operand concatenated with itself: the bits that
  // fall off one end reappear from the copy at the other end.
  assign rol_full = {a, a} << sh;
  assign ror_full = {a, a} >> sh;
  assign sra      = $unsigned($signed(a) >>> sh);

  always_comb begin
    res  = '0;
    cout = 1'b0;
    err  = lu_op_is_illegal(op);
    case (op)
      LU_AND:  res = a & b;
      LU_OR:   res = a | b;
      LU_NOR:  res = ~(a | b);
      LU_NOT:  res = ~a;
      LU_XOR:  res = a ^ b;
      LU_NAND: res = ~(a & b);
      LU_XNOR: res = ~(a ^ b);
      LU_NEG: begin
        res  = neg_sum[WIDTH-1:0];
        cout = neg_sum[WIDTH];
      end
      LU_SHL:  res = a << sh;
      LU_SHR:  res = a >> sh;
      LU_SRA:  res = sra;
      LU_ROL:  res = rol_full[2*WIDTH-1:WIDTH];
      LU_ROR:  res = ror_full[WIDTH-1:0];
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with valid/ready handshakes on both sides.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : op handshake; in_op, in_a, in_b, in_tag carry the op
//   out_valid/out_ready: result handshake
//   out_res, out_tag   : result and the tag of the op that produced it
//   out_zero, out_neg  : result == 0, result sign bit
//   out_cout, out_err  : NEG carry out, illegal opcode
// Stage 1 registers the op; the core evaluates it combinationally and stage 2
// registers the result together with its flags.
module logic_unit_pipe
  import lu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_cout,
  output logic             out_err
);

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;

  logic [WIDTH-1:0] core_res;
  logic             core_cout;
  logic             core_err;
  logic             advance;

  // Stage 2 can take a new result when it is empty or being drained now.
  assign advance   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || advance;
  assign out_valid = s2_valid;

  lu_core #(.WIDTH(WIDTH)) u_core (
    .op   (s1_op),
    .a    (s1_a),
    .b    (s1_b),
    .res  (core_res),
    .cout (core_cout),
    .err  (core_err)
  );

  // Stage-1 payload carries no reset; it is qualified by s1_valid.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_op  <= in_op;
      s1_a   <= in_a;
      s1_b   <= in_b;
      s1_tag <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_res  <= '0;
      out_tag  <= '0;
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
      out_cout <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_res  <= core_res;
          out_tag  <= s1_tag;
          out_zero <= (core_res == '0);
          out_neg  <= core_res[WIDTH-1];
          out_cout <= core_cout;
          out_err  <= core_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

  localparam int W  = 64;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic [TW-1:0] out_tag;
  logic          out_zero;
  logic          out_neg;
  logic          out_cout;
  logic          out_err;

  logic_unit_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_tag(out_tag), .out_zero(out_zero), .out_neg(out_neg),
    .out_cout(out_cout), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          cout;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_sent  = 0;
  int   n_rcv   = 0;
  int   cyc     = 0;
  int   stall_lo = 1;
  int   stall_hi = 0;
  bit   rand_rdy = 0;
  bit   saw_not_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: operations expressed directly from their definitions.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic c, output logic e);
    int n;
    n = int'(b % W);
    r = a; c = 0; e = 0;
    case (op)
      0:  r = a & b;
      1:  r = a | b;
      2:  r = ~(a | b);
      3:  r = ~a;
      4:  r = a ^ b;
      5:  r = ~(a & b);
      6:  r = ~(a ^ b);
      7:  begin r = 0 - a; c = (a == 0); end
      8:  repeat (n) r = {r[W-2:0], 1'b0};
      9:  repeat (n) r = {1'b0, r[W-1:1]};
      10: repeat (n) r = {r[W-1], r[W-1:1]};
      11: repeat (n) r = {r[W-2:0], r[W-1]};
      12: repeat (n) r = {r[0], r[W-1:1]};
      default: begin r = 0; e = 1; end
    endcase
  endfunction

  function automatic logic rdy_fn();
    if (rand_rdy) return ($urandom_range(3) != 0);
    return !(cyc >= stall_lo && cyc <= stall_hi);
  endfunction

  // Starts and ends just after a rising edge; holds the op until accepted.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input logic [W-1:0] er,
                       input logic ec, input logic ee);
    bit acc = 0;
    int tries = 0;
    while (!acc && tries < 64) begin
      out_ready = rdy_fn();
      in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag;
      #1;
      acc = in_ready;
      if (!acc) saw_not_ready = 1;
      @(posedge clk); #1;
      tries++;
    end
    if (acc) begin
      q.push_back('{res: er, tag: tag, cout: ec, err: ee});
      n_sent++;
    end else begin
      check("issue_timeout", {63'd0, acc}, 1);
    end
  endtask

  task automatic issue_m(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] tag);
    logic [W-1:0] r; logic c, e;
    model(op, a, b, r, c, e);
    issue(op, a, b, tag, r, c, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 0;
      out_ready = rdy_fn();
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin idle(1); t++; end
    check("drain_empty", q.size(), 0);
  endtask

  // Output monitor: scoreboard compare on every transfer, stability while stalled.
  logic          prev_stall = 0;
  logic [W-1:0]  prev_res;
  logic [TW-1:0] prev_tag;
  logic [3:0]    prev_flags;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_res", out_res, prev_res);
        check("stall_tag", out_tag, prev_tag);
        check("stall_flags", {out_zero, out_neg, out_cout, out_err}, prev_flags);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("out_unexpected", out_valid, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          n_rcv++;
          $display("[TB] out tag=%0d res=%h z=%0b n=%0b c=%0b e=%0b exp_res=%h",
                   out_tag, out_res, out_zero, out_neg, out_cout, out_err, e.res);
          check("res", out_res, e.res);
          check("tag", out_tag, e.tag);
          check("zero", out_zero, e.res == 0);
          check("neg", out_neg, e.res[W-1]);
          check("cout", out_cout, e.cout);
          check("err", out_err, e.err);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_res;
      prev_tag   = out_tag;
      prev_flags = {out_zero, out_neg, out_cout, out_err};
    end
  end

  initial begin
    rst = 1; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_res", out_res, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_flags", {out_zero, out_neg, out_cout, out_err}, 0);

    // 1: single AND with latency check
    issue(4'd0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 6'd5,
          64'hF000_F000_F000_F000, 0, 0);
    in_valid = 0;
    check("lat_s1_only", out_valid, 0);
    @(posedge clk); #1;
    check("lat_out_valid", out_valid, 1);
    check("lat_res", out_res, 64'hF000_F000_F000_F000);
    check("lat_tag", out_tag, 5);
    check("lat_zero", out_zero, 0);
    check("lat_neg", out_neg, 1);
    idle(2);

    // 2: NEG boundaries
    issue(4'd7, 64'd0, 64'h1234, 6'd1, 64'd0, 1, 0);
    issue(4'd7, 64'd1, 64'd0, 6'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    // 3: shifts and rotates, amount 1 and 0x41
    issue(4'd8,  64'h8000_0000_0000_0001, 64'd1, 6'd3, 64'h2, 0, 0);
    issue(4'd9,  64'h8000_0000_0000_0001, 64'd1, 6'd4, 64'h4000_0000_0000_0000, 0, 0);
    issue(4'd10, 64'h8000_0000_0000_0001, 64'd1, 6'd5, 64'hC000_0000_0000_0000, 0, 0);
    issue(4'd11, 64'h8000_0000_0000_0001, 64'd1, 6'd6, 64'h3, 0, 0);
    issue(4'd12, 64'h8000_0000_0000_0001, 64'd1, 6'd7, 64'hC000_0000_0000_0000, 0, 0);
    issue(4'd8,  64'h8000_0000_0000_0001, 64'h41, 6'd8, 64'h2, 0, 0);
    issue(4'd10, 64'h8000_0000_0000_0001, 64'h41, 6'd9, 64'hC000_0000_0000_0000, 0, 0);
    issue(4'd12, 64'h8000_0000_0000_0001, 64'h41, 6'd10, 64'hC000_0000_0000_0000, 0, 0);
    // 4: illegal op, then a legal one
    issue(4'd14, 64'hDEAD_BEEF_0000_0001, 64'h55, 6'd11, 64'd0, 0, 1);
    issue(4'd4, 64'h00FF, 64'h0F0F, 6'd12, 64'h0FF0, 0, 0);
    drain();

    // 5: backpressure window on cycles 3..6 of an 8-op stream
    saw_not_ready = 0;
    stall_lo = cyc + 3;
    stall_hi = cyc + 6;
    for (int i = 0; i < 8; i++)
      issue_m(4'(i), {$urandom, $urandom}, {$urandom, $urandom}, 6'(20 + i));
    drain();
    check("bp_in_ready_dropped", {63'd0, saw_not_ready}, 1);
    stall_lo = 1; stall_hi = 0;

    // 6: reset with two ops in flight
    issue_m(4'd1, 64'h1111, 64'h2222, 6'd40);
    issue_m(4'd4, 64'h3333, 64'h4444, 6'd41);
    in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    q.delete();
    rst = 0;
    idle(6);
    check("rst_no_stale", out_valid, 0);

    // Random traffic with random consumer stalls
    rand_rdy = 1;
    for (int i = 0; i < 250; i++) begin
      logic [W-1:0] a;
      a = ($urandom_range(9) == 0) ? 64'd0 : {$urandom, $urandom};
      issue_m(4'($urandom_range(15)), a, {$urandom, $urandom}, 6'($urandom));
      if ($urandom_range(7) == 0) idle(1);
    end
    rand_rdy = 0;
    out_ready = 1;
    drain();
    check("rcv_count", n_rcv, n_sent - 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
